// File: rtl/shift_pkg.sv
// Shared types for the iterative shift unit.
// Defaults, op codes and FSM state encodings.
package shift_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shift datapath.
// Moves acc by 1 bit, or by 4 bits when step4 is set.
module shift_step
  import shift_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] acc,
  input  logic [1:0]      op_r,
  input  logic            step4,
  output logic [XLEN-1:0] acc_nxt
);

  logic fill;

  always_comb begin
    fill    = (op_r == OP_SRA) & acc[XLEN-1];
    acc_nxt = acc;
    case (op_r)
      OP_SRL,
      OP_SRA: begin
        if (step4)
          acc_nxt = {{4{fill}}, acc[XLEN-1:4]};
        else
          acc_nxt = {fill, acc[XLEN-1:1]};
      end
      // reserved encoding behaves as SLL
      default: begin
        if (step4)
          acc_nxt = {acc[XLEN-5:0], 4'b0000};
        else
          acc_nxt = {acc[XLEN-2:0], 1'b0};
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative SLL/SRL/SRA unit with valid/ready handshake and flush.
// Define SHIFT_SEQ_FAST_STEP_EN to take 4-bit steps while cnt >= 4.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [XLEN-1:0]    A,
  input  logic [SHAMT_W-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]    acc_step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [SHAMT_W-1:0] cnt_step;
  logic [1:0]         op_q, op_d;
  logic               step4;
  logic               accept;
  logic               last_step;

`ifdef SHIFT_SEQ_FAST_STEP_EN
  assign step4 = (cnt_q >= SHAMT_W'(4));
`else
  assign step4 = 1'b0;
`endif

  assign cnt_step  = cnt_q - (step4 ? SHAMT_W'(4) : SHAMT_W'(1));
  assign last_step = (cnt_step == '0);
  assign accept    = in_valid & in_ready;

  shift_step #(
    .XLEN (XLEN)
  ) u_step (
    .acc     (acc_q),
    .op_r    (op_q),
    .step4   (step4),
    .acc_nxt (acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept)
            state_d = (B == '0) ? ST_DONE : ST_SHIFT;
        end
        ST_SHIFT: begin
          if (last_step)
            state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready)
            state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    if (!flush) begin
      if (state_q == ST_IDLE && accept) begin
        acc_d = A;
        cnt_d = B;
        op_d  = op;
      end else if (state_q == ST_SHIFT) begin
        acc_d = acc_step;
        cnt_d = cnt_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      op_q  <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) & ~flush;
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_SHIFT) | (state_q == ST_DONE);
    out       = acc_q;
  end

endmodule
